// File: rtl/pipe_ctrl.sv
// Hazard/stall control with a small MDU busy tracker.
// Optional stall-cycle counter enabled by PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic [4:0]  A3_E,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  Tnew_E,
  input  logic [1:0]  Tnew_M,
  input  logic        RegWrite_E,
  input  logic        RegWrite_M,
  input  logic        MD_D,
  input  logic        Start_E,
  input  logic        DivOp_E,
  input  logic        Req,
  output logic        stall,
  output logic        en_PC,
  output logic        en_FD,
  output logic        flush_DE,
  output logic        Busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e  state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic rs_hit_e, rs_hit_m;
  logic rt_hit_e, rt_hit_m;
  logic stall_rs, stall_rt, stall_md;

  always_comb begin
    rs_hit_e = RegWrite_E
             && (A3_E == A1_D)
             && (Tuse_rs_D < Tnew_E);
    rs_hit_m = RegWrite_M
             && (A3_M == A1_D)
             && (Tuse_rs_D < Tnew_M);
    rt_hit_e = RegWrite_E
             && (A3_E == A2_D)
             && (Tuse_rt_D < Tnew_E);
    rt_hit_m = RegWrite_M
             && (A3_M == A2_D)
             && (Tuse_rt_D < Tnew_M);
    // $0 is hardwired, so it never carries a dependency
    stall_rs = (A1_D != 5'd0)
             && (rs_hit_e || rs_hit_m);
    stall_rt = (A2_D != 5'd0)
             && (rt_hit_e || rt_hit_m);
    stall_md = MD_D && (Busy || Start_E);
    stall    = (stall_rs || stall_rt || stall_md)
             && !Req;
    en_PC    = !stall;
    en_FD    = !stall;
    flush_DE = stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Start_E && !Req) begin
          state_d  = BUSY;
          md_cnt_d = DivOp_E ? 4'd10 : 4'd5;
        end
      end
      BUSY: begin
        // a running count is not affected by Req
        if (md_cnt_q <= 4'd1) begin
          state_d  = IDLE;
          md_cnt_d = 4'd0;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    Busy   = (state_q == BUSY);
    md_cnt = md_cnt_q;
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt_q <= 32'd0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: reference model plus directed vectors.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1_D, A2_D, A3_E, A3_M;
  logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic        RegWrite_E, RegWrite_M;
  logic        MD_D, Start_E, DivOp_E, Req;
  logic        stall, en_PC, en_FD, flush_DE, Busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .A1_D(A1_D), .A2_D(A2_D),
    .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .A3_E(A3_E), .A3_M(A3_M),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M),
    .MD_D(MD_D), .Start_E(Start_E), .DivOp_E(DivOp_E),
    .Req(Req),
    .stall(stall), .en_PC(en_PC), .en_FD(en_FD),
    .flush_DE(flush_DE), .Busy(Busy),
    .md_cnt(md_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: cycles of MDU work left and stall total
  int     m_left;
  longint m_cnt;
  bit     e_stall;

  always_comb begin
    bit d_rs, d_rt, d_md;
    d_rs = (A1_D != 0) &&
      ((RegWrite_E && A3_E == A1_D && Tuse_rs_D < Tnew_E) ||
       (RegWrite_M && A3_M == A1_D && Tuse_rs_D < Tnew_M));
    d_rt = (A2_D != 0) &&
      ((RegWrite_E && A3_E == A2_D && Tuse_rt_D < Tnew_E) ||
       (RegWrite_M && A3_M == A2_D && Tuse_rt_D < Tnew_M));
    d_md = MD_D && ((m_left > 0) || Start_E);
    e_stall = (d_rs || d_rt || d_md) && !Req;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_cnt  <= 0;
    end else begin
      if (m_left > 0)
        m_left <= m_left - 1;
      else if (Start_E && !Req)
        m_left <= DivOp_E ? 10 : 5;
      if (e_stall && m_cnt < 64'hFFFF_FFFF)
        m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic longint exp_perf(input longint n);
`ifdef PIPE_CTRL_PERF_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", stall, e_stall);
      chk("m_en_PC", en_PC, !e_stall);
      chk("m_en_FD", en_FD, !e_stall);
      chk("m_flush", flush_DE, e_stall);
      chk("m_busy", Busy, m_left > 0);
      chk("m_md_cnt", md_cnt, m_left);
      chk("m_stall_cnt", stall_cnt, exp_perf(m_cnt));
    end
  end

  task automatic clr();
    A1_D = 0; A2_D = 0; A3_E = 0; A3_M = 0;
    Tuse_rs_D = 0; Tuse_rt_D = 0;
    Tnew_E = 0; Tnew_M = 0;
    RegWrite_E = 0; RegWrite_M = 0;
    MD_D = 0; Start_E = 0; DivOp_E = 0; Req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    RegWrite_E = 1; A3_E = 5; Tnew_E = 2;
    A1_D = 5; Tuse_rs_D = 0;
  endtask

  initial begin
    reset = 0;
    clr();
    #1 chk_en = 1'b1;
    step();
    step();
    chk("rst_busy", Busy, 0);
    chk("rst_md_cnt", md_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    reset = 1;
    step();

    // load-use on rs
    load_use();
    @(negedge clk);
    chk("lu_stall", stall, 1);
    chk("lu_en_PC", en_PC, 0);
    chk("lu_en_FD", en_FD, 0);
    chk("lu_flush", flush_DE, 1);
    step();

    // $0 never stalls
    A1_D = 0; A3_E = 0;
    @(negedge clk);
    chk("zero_stall", stall, 0);
    step();

    // rt vs M stage, then Tuse == Tnew boundary
    clr();
    RegWrite_M = 1; A3_M = 7; Tnew_M = 1;
    A2_D = 7; Tuse_rt_D = 0;
    @(negedge clk);
    chk("rtm_stall", stall, 1);
    step();
    Tuse_rt_D = 1;
    @(negedge clk);
    chk("rtm_eq_stall", stall, 0);
    step();

    // Req overrides a hazard
    clr();
    load_use();
    Req = 1;
    @(negedge clk);
    chk("req_stall", stall, 0);
    step();

    // mult: five busy cycles
    clr();
    MD_D = 1; Start_E = 1; DivOp_E = 0;
    step();
    Start_E = 0;
    for (int i = 5; i >= 1; i--) begin
      @(negedge clk);
      chk("mul_md_cnt", md_cnt, i);
      chk("mul_busy", Busy, 1);
      chk("mul_stall", stall, 1);
    end
    @(negedge clk);
    chk("mul_end_cnt", md_cnt, 0);
    chk("mul_end_busy", Busy, 0);
    step();

    // div with Req: no start
    clr();
    Start_E = 1; DivOp_E = 1; Req = 1;
    step();
    clr();
    @(negedge clk);
    chk("divreq_busy", Busy, 0);
    step();

    // Req during a running div
    Start_E = 1; DivOp_E = 1;
    step();
    clr();
    step();
    MD_D = 1; Req = 1;
    @(negedge clk);
    chk("busyreq_stall", stall, 0);
    chk("busyreq_cnt", md_cnt, 9);
    step();
    @(negedge clk);
    chk("busyreq_cnt2", md_cnt, 8);
    step();
    clr();
    repeat (9) step();

    // reset in the middle of a div
    Start_E = 1; DivOp_E = 1;
    step();
    clr();
    repeat (4) @(posedge clk);
    #1 chk("pre_rst_cnt", md_cnt, 6);
    #1 reset = 0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_md_cnt", md_cnt, 0);
    step();
    reset = 1;
    Start_E = 1; DivOp_E = 0;
    step();
    Start_E = 0;
    chk("restart_cnt", md_cnt, 5);
    chk("restart_busy", Busy, 1);
    repeat (6) step();

    // perf counter: three stalled cycles from a fresh reset
    reset = 0;
    step();
    reset = 1;
    load_use();
    repeat (3) step();
    clr();
    @(negedge clk);
    chk("perf_cnt", stall_cnt, exp_perf(3));
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low (0 = reset).
REQ-003 SHALL have inputs A1_D and A2_D, 5 bits each: rs/rt read addresses in D.
REQ-004 SHALL have inputs Tuse_rs_D and Tuse_rt_D, 2 bits each: cycles until D-stage instruction needs rs/rt.
REQ-005 SHALL have inputs A3_E, A3_M (5 bits), Tnew_E, Tnew_M (2 bits) and RegWrite_E, RegWrite_M (1 bit): pending writers in E and M.
REQ-006 SHALL have input MD_D, 1 bit: D-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-007 SHALL have inputs Start_E (1 bit, mult/div issuing in E) and DivOp_E (1 bit, 1 = div, 0 = mult).
REQ-008 SHALL have input Req, 1 bit: exception/interrupt request from CP0.
REQ-009 SHALL have outputs stall (1), en_PC (1), en_FD (1), flush_DE (1) and Busy (1).
REQ-010 SHALL have output md_cnt, 4 bits: remaining MDU busy cycles.
REQ-011 SHALL have output stall_cnt, 32 bits: stall-cycle count (see Configuration).

Function
REQ-012 SHALL assert stall_rs when A1_D != 0 and either (RegWrite_E, A3_E == A1_D, Tuse_rs_D < Tnew_E) or (RegWrite_M, A3_M == A1_D, Tuse_rs_D < Tnew_M).
REQ-013 SHALL assert stall_rt under the REQ-012 conditions, substituting A2_D and Tuse_rt_D.
REQ-014 SHALL assert stall_md when MD_D and (Busy or Start_E).
REQ-015 SHALL drive stall = (stall_rs | stall_rt | stall_md) & ~Req, combinationally, same cycle.
REQ-016 SHALL drive en_PC = en_FD = ~stall; flush_DE = stall.
REQ-017 SHALL implement MDU FSM with states IDLE and BUSY; Busy = (state == BUSY).
REQ-018 In IDLE, on Start_E & ~Req, SHALL go to BUSY and load md_cnt = 10 if DivOp_E, else 5.
REQ-019 In BUSY, SHALL decrement md_cnt by 1 per cycle; on the edge where md_cnt == 1, SHALL load 0 and return to IDLE.
REQ-020 md_cnt SHALL never wrap; it stays 0 in IDLE.
REQ-021 Start_E in BUSY SHALL be ignored, since a stall_md precludes it.
REQ-022 Start_E coincident with Req SHALL NOT start the MDU; a BUSY count already running SHALL continue to completion under Req.
REQ-023 Req SHALL override every hazard: stall = 0 in that cycle, regardless of dependencies or Busy.

Reset
REQ-024 When reset is low, SHALL immediately force state = IDLE, md_cnt = 0, Busy = 0 and stall_cnt = 0, independent of clk.
REQ-025 Reset asserted mid-BUSY SHALL abort the count; after release, the FSM SHALL accept a new Start_E on the next edge.
REQ-026 Combinational outputs under reset SHALL follow REQ-015/016 with Busy = 0.

Configuration
REQ-027 Macro PIPE_CTRL_PERF_CNT_EN SHALL gate the stall counter.
REQ-028 With PIPE_CTRL_PERF_CNT_EN defined, stall_cnt SHALL increment by 1 on each rising edge where stall = 1, and SHALL saturate at 32'hFFFFFFFF.
REQ-029 Without PIPE_CTRL_PERF_CNT_EN, stall_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-030 Load-use: RegWrite_E=1, A3_E=5, Tnew_E=2, A1_D=5, Tuse_rs_D=0 -> stall=1, en_PC=0, en_FD=0, flush_DE=1 same cycle.
REQ-031 $0 immunity: as REQ-030 but A1_D=A3_E=0 -> stall=0.
REQ-032 Mult: Start_E=1, DivOp_E=0 for one cycle -> Busy=1 for exactly 5 cycles, md_cnt 5,4,3,2,1,0; MD_D=1 throughout -> stall=1 for those cycles.
REQ-033 Div plus Req: Start_E=1, DivOp_E=1, Req=1 same cycle -> Busy remains 0; separately, Req=1 during a BUSY count -> stall=0 and the count continues.
REQ-034 Reset mid-div: reset low at md_cnt=6 -> Busy=0 and md_cnt=0 before the next clk edge.
REQ-035 Perf counter: with PIPE_CTRL_PERF_CNT_EN defined, 3 stalled cycles -> stall_cnt=3; without the macro -> stall_cnt=0.
